// File: rtl/booth_pkg.sv
// booth_pkg: shared encodings and control-word decode for the Booth multiplier controller
package booth_pkg;
   localparam int DEF_DATA_WIDTH = 16;
   localparam int DEF_COUNT_W = 4;
   localparam logic ALU_ADD = 1'b0;
   localparam logic ALU_SUB = 1'b1;
   localparam logic [2:0] S_IDLE = 3'd0;
   localparam logic [2:0] S_LDM = 3'd1;
   localparam logic [2:0] S_LDQ = 3'd2;
   localparam logic [2:0] S_EVAL = 3'd3;
   localparam logic [2:0] S_ADD = 3'd4;
   localparam logic [2:0] S_SHIFT = 3'd5;
   localparam logic [2:0] S_DONE = 3'd6;
   typedef enum logic [2:0] {
      IDLE = S_IDLE,
      LDM = S_LDM,
      LDQ = S_LDQ,
      EVAL = S_EVAL,
      ADD = S_ADD,
      SHIFT = S_SHIFT,
      DONE = S_DONE
   } state_t;
   typedef struct packed {
      logic busy;
      logic done;
      logic opSel;
      logic loadA;
      logic clearA;
      logic shiftA;
      logic loadQ;
      logic clearQ;
      logic shiftQ;
      logic loadM;
      logic clearM;
      logic clearff;
      logic addSub;
      logic clearCounter;
      logic decr;
   } ctrl_t;
   // eqz is stable from the previous shift until the next one, so the decrement can be decided on entry to SHIFT
   function automatic ctrl_t ctrlFor(state_t s, logic sub, logic eqz);
      ctrl_t c;
      c = '0;
      c.busy = (s != IDLE);
      c.done = (s == DONE);
      c.opSel = (s == LDQ);
      c.loadM = (s == LDM);
      c.clearA = (s == LDM);
      c.clearCounter = (s != LDM);
      c.loadQ = (s == LDQ);
      c.clearff = (s == LDQ);
      c.loadA = (s == ADD);
      c.shiftA = (s == SHIFT);
      c.shiftQ = (s == SHIFT);
      c.addSub = sub;
      c.decr = (s == SHIFT) && !eqz;
      return c;
   endfunction
endpackage

// File: rtl/booth_controller.sv
// booth_controller: sequencing FSM driving every control line of a radix-2 Booth multiplier datapath
module booth_controller
   import booth_pkg::*;
#(
   parameter int DATA_WIDTH = DEF_DATA_WIDTH,
   parameter int COUNT_W = DEF_COUNT_W
) (
   input  logic clk,
   input  logic clear,
   input  logic start,
   input  logic eqz,
   input  logic q0,
   input  logic qm1,
   output logic busy,
   output logic done,
   output logic op_sel,
   output logic loadA,
   output logic clearA,
   output logic shiftA,
   output logic loadQ,
   output logic clearQ,
   output logic shiftQ,
   output logic loadM,
   output logic clearM,
   output logic clearff,
   output logic addSub,
   output logic clearCounter,
   output logic decr,
   output logic count_en
);
   if (DATA_WIDTH != 2 ** COUNT_W) begin : gBadWidth
      $error("DATA_WIDTH must equal 2**COUNT_W");
   end
   state_t state, nextState;
   logic subReg, nextSub;
   ctrl_t ctrl;
   always_comb begin
      nextState = IDLE;
      case (state)
         IDLE: nextState = start ? LDM : IDLE;
         LDM: nextState = LDQ;
         LDQ: nextState = EVAL;
         EVAL: nextState = (q0 ^ qm1) ? ADD : SHIFT;
         ADD: nextState = SHIFT;
         SHIFT: nextState = eqz ? DONE : EVAL;
         default: nextState = IDLE;
      endcase
   end
   assign nextSub = (state == EVAL && q0 && !qm1) ? ALU_SUB :
                    (state == EVAL && !q0 && qm1) ? ALU_ADD : subReg;
   always_ff @(posedge clk or posedge clear) begin
      if (clear) begin
         state <= IDLE;
         subReg <= ALU_ADD;
         ctrl <= ctrlFor(IDLE, ALU_ADD, 1'b1);
      end else begin
         state <= nextState;
         subReg <= nextSub;
         ctrl <= ctrlFor(nextState, nextSub, eqz);
      end
   end
   assign busy = ctrl.busy;
   assign done = ctrl.done;
   assign op_sel = ctrl.opSel;
   assign loadA = ctrl.loadA;
   assign clearA = ctrl.clearA;
   assign shiftA = ctrl.shiftA;
   assign loadQ = ctrl.loadQ;
   assign clearQ = ctrl.clearQ;
   assign shiftQ = ctrl.shiftQ;
   assign loadM = ctrl.loadM;
   assign clearM = ctrl.clearM;
   assign clearff = ctrl.clearff;
   assign addSub = ctrl.addSub;
   assign clearCounter = ctrl.clearCounter;
   assign decr = ctrl.decr;
   assign count_en = ctrl.decr;
endmodule

// File: tb/tb_booth_controller.sv
// tb_booth_controller: controller plus behavioural datapath, checked against plain signed multiplication
module tb_booth_controller;
   logic clk = 1'b0;
   logic clear = 1'b0;
   logic start = 1'b0;
   logic eqz, q0, qm1;
   logic busy, done, op_sel, loadA, clearA, shiftA, loadQ, clearQ, shiftQ;
   logic loadM, clearM, clearff, addSub, clearCounter, decr, count_en;
   logic [15:0] mm = '0, mq = '0, dataIn, mReg = '0, qReg = '0;
   logic [16:0] aReg = '0;
   logic qm1Reg = 1'b0;
   logic [3:0] cnt = '0;
   typedef struct {
      logic [31:0] prod;
      int r;
      int startEdge;
   } exp_t;
   exp_t sb[$];
   int checks = 0, fails = 0, cyc = 0, issued = 0, doneSeen = 0, loadACnt = 0;
   bit afterDone = 1'b0;

   booth_controller dut (
      .clk(clk), .clear(clear), .start(start), .eqz(eqz), .q0(q0), .qm1(qm1),
      .busy(busy), .done(done), .op_sel(op_sel), .loadA(loadA), .clearA(clearA),
      .shiftA(shiftA), .loadQ(loadQ), .clearQ(clearQ), .shiftQ(shiftQ), .loadM(loadM),
      .clearM(clearM), .clearff(clearff), .addSub(addSub), .clearCounter(clearCounter),
      .decr(decr), .count_en(count_en)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   // A carries a guard bit so the max-negative multiplicand cannot overflow the accumulator
   assign dataIn = op_sel ? mq : mm;
   assign eqz = (cnt == 4'd0);
   assign q0 = qReg[0];
   assign qm1 = qm1Reg;
   always @(posedge clk) begin
      if (clearA) aReg <= '0;
      else if (loadA) aReg <= addSub ? aReg - {mReg[15], mReg} : aReg + {mReg[15], mReg};
      else if (shiftA) aReg <= {aReg[16], aReg[16:1]};
      if (clearM) mReg <= '0;
      else if (loadM) mReg <= dataIn;
      if (clearQ) qReg <= '0;
      else if (loadQ) qReg <= dataIn;
      else if (shiftQ) qReg <= {aReg[0], qReg[15:1]};
      qm1Reg <= clearff ? 1'b0 : qReg[0];
      if (!clearCounter) cnt <= 4'd15;
      else if (decr && count_en) cnt <= cnt - 4'd1;
   end

   function automatic int recodes(logic [15:0] q);
      int r = 0;
      logic p = 1'b0;
      for (int i = 0; i < 16; i++) begin
         if (q[i] != p) r++;
         p = q[i];
      end
      return r;
   endfunction

   function automatic logic [31:0] refProd(logic [15:0] m, logic [15:0] q);
      int a, b;
      a = $signed(m);
      b = $signed(q);
      return 32'(a * b);
   endfunction

   always @(negedge clk) begin
      if (clear) begin
         loadACnt = 0;
         afterDone = 1'b0;
      end else begin
         checks++;
         if ((loadA && shiftA) || (loadQ && shiftQ)) begin
            fails++;
            $display("FAIL strobe_overlap loadA=%b shiftA=%b loadQ=%b shiftQ=%b required no overlap", loadA, shiftA, loadQ, shiftQ);
         end
         if (afterDone) begin
            checks++;
            if (done || busy) begin
               fails++;
               $display("FAIL after_done done=%b busy=%b required 0 0", done, busy);
            end
            afterDone = 1'b0;
         end
         if (loadA) loadACnt++;
         if (done) begin
            doneSeen++;
            checks++;
            if (sb.size() == 0) begin
               fails++;
               $display("FAIL spurious_done at cycle %0d with nothing outstanding", cyc);
            end else begin
               exp_t e;
               e = sb.pop_front();
               if ({aReg[15:0], qReg} !== e.prod) begin
                  fails++;
                  $display("FAIL product got=%h expected=%h", {aReg[15:0], qReg}, e.prod);
               end
               checks++;
               if (cyc - e.startEdge != 34 + e.r) begin
                  fails++;
                  $display("FAIL latency got=%0d expected=%0d", cyc - e.startEdge, 34 + e.r);
               end
               checks++;
               if (loadACnt != e.r) begin
                  fails++;
                  $display("FAIL add_count got=%0d expected=%0d", loadACnt, e.r);
               end
            end
            loadACnt = 0;
            afterDone = 1'b1;
         end
      end
   end

   task automatic chkOut(string nm);
      logic [15:0] o;
      o = {busy, done, op_sel, loadA, clearA, shiftA, loadQ, clearQ, shiftQ,
           loadM, clearM, clearff, addSub, clearCounter, decr, count_en};
      checks++;
      if (o !== 16'h0004) begin
         fails++;
         $display("FAIL %s outputs=%h expected=%h", nm, o, 16'h0004);
      end
   endtask

   task automatic push(logic [15:0] m, logic [15:0] q, int se);
      exp_t e;
      e.prod = refProd(m, q);
      e.r = recodes(q);
      e.startEdge = se;
      sb.push_back(e);
      issued++;
   endtask

   task automatic waitIdle();
      int n = 0;
      while (sb.size() != 0 && n < 300) begin
         @(negedge clk);
         n++;
      end
      if (sb.size() != 0) begin
         checks++;
         fails++;
         $display("FAIL timeout outstanding=%0d required 0", sb.size());
         issued -= sb.size();
         sb.delete();
      end
   endtask

   task automatic issue(logic [15:0] m, logic [15:0] q);
      @(negedge clk);
      mm = m;
      mq = q;
      start = 1'b1;
      push(m, q, cyc + 1);
      @(negedge clk);
      start = 1'b0;
   endtask

   task automatic runOp(logic [15:0] m, logic [15:0] q);
      waitIdle();
      issue(m, q);
   endtask

   initial begin
      int n, shifts, s1, s2;
      logic [15:0] m1, q1;
      #1 clear = 1'b1;
      repeat (2) @(negedge clk);
      #1 chkOut("reset_outputs");
      @(negedge clk);
      clear = 1'b0;
      runOp(16'd3, 16'd5);
      runOp(16'hFFFD, 16'd7);
      runOp(16'h8000, 16'h8000);
      runOp(16'($urandom), 16'h0000);
      runOp(16'($urandom), 16'hFFFF);
      runOp(16'h7FFF, 16'h8000);
      runOp(16'h8000, 16'h7FFF);
      runOp(16'hFFFF, 16'hFFFF);
      for (int i = 0; i < 16; i++) runOp(16'($urandom), 16'($urandom));
      waitIdle();
      issue(16'($urandom), 16'($urandom));
      n = 0;
      shifts = 0;
      while (shifts < 5 && n < 200) begin
         @(negedge clk);
         n++;
         if (shiftA) shifts++;
      end
      clear = 1'b1;
      #1 chkOut("abort_outputs");
      checks++;
      if (shifts != 5) begin
         fails++;
         $display("FAIL abort_shift_wait got=%0d required 5", shifts);
      end
      void'(sb.pop_back());
      issued--;
      @(negedge clk);
      clear = 1'b0;
      runOp(16'd2, 16'hFFFF);
      waitIdle();
      issue(16'($urandom), 16'($urandom));
      repeat (10) @(negedge clk);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      waitIdle();
      repeat (60) @(negedge clk);
      waitIdle();
      @(negedge clk);
      m1 = 16'($urandom);
      q1 = 16'($urandom);
      mm = m1;
      mq = q1;
      start = 1'b1;
      s1 = cyc + 1;
      push(m1, q1, s1);
      repeat (4) @(negedge clk);
      s2 = s1 + 34 + recodes(q1) + 2;
      mm = 16'($urandom);
      mq = 16'($urandom);
      push(mm, mq, s2);
      n = 0;
      while (cyc < s2 + 3 && n < 200) begin
         @(negedge clk);
         n++;
      end
      start = 1'b0;
      waitIdle();
      repeat (60) @(negedge clk);
      checks++;
      if (doneSeen != issued) begin
         fails++;
         $display("FAIL done_count got=%0d expected=%0d", doneSeen, issued);
      end
      $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog simulation did not finish");
      $fatal(1);
   end
endmodule
